// File: rtl/gc_pkg.sv
// gc_pkg - shared types and helpers for the global-controller sequencer.
//   gc_state_e  : 3-bit FSM state encoding (5..7 are illegal)
//   pe_kick()   : all-ones mask of a given width, used as the PE start kick
//   state_name(): printable state name for benches and debug
package gc_pkg;

  typedef enum logic [2:0] {
    ST_CONFIG = 3'd0,
    ST_INIT   = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_FINAL  = 3'd4
  } gc_state_e;

  localparam int MAX_IC = 32;

  function automatic logic [MAX_IC-1:0] pe_kick(input int n);
    logic [MAX_IC-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_IC; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

  function automatic string state_name(input logic [2:0] s);
    case (s)
      3'd0:    return "CONFIG";
      3'd1:    return "INIT";
      3'd2:    return "RUN";
      3'd3:    return "PAUSE";
      3'd4:    return "FINAL";
      default: return "ILLEGAL";
    endcase
  endfunction

endpackage

// File: rtl/gc_sequencer_ic_delay.sv
// gc_ic_delay - WIDTH x DEPTH shift register carrying IC signals to the PEs.
//   clk      : clock
//   clear    : synchronous clear of every stage
//   shift_en : advance the line by one stage
//   din      : value entering stage 0
//   dout     : last stage
module gc_ic_delay #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else if (shift_en) begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/gc_sequencer.sv
// gc_sequencer - global-controller FSM for the TCPA PE array.
// Sequences CONFIG -> INIT -> RUN -> (PAUSE) -> FINAL, one step per
// iteration-interval tick; drives the iteration vector and delayed IC bits.
//   inputs : gc_clk, reset (sync, active high), config_done, dcm_lock,
//            start, stop, restart_mode, restart_ext, reinitialize,
//            init_ivar, ivar_next, init_ic, ic_in, iteration_interval
//   outputs: conf_en, current_state, x_bus_reg, ic, global_en, tick,
//            pass_count, done
//
// state  | meaning
// CONFIG | waiting for loader and start; x bus and IC held at 0
// INIT   | initial iteration vector presented; next tick kicks the PEs
// RUN    | stepping through iteration points
// PAUSE  | stopped mid-run; x bus held, IC fed zeros
// FINAL  | last point done; waiting for an external restart
module gc_sequencer
  import gc_pkg::*;
#(
  parameter int DIMENSION  = 3,
  parameter int IVAR_WIDTH = 16,
  parameter int NUM_IC     = 3,
  parameter int IC_DELAY   = 4,
  parameter int II_WIDTH   = 16,
  parameter int PASS_WIDTH = 8
) (
  input  logic                            gc_clk,
  input  logic                            reset,
  input  logic                            config_done,
  input  logic                            dcm_lock,
  input  logic                            start,
  input  logic                            stop,
  input  logic                            restart_mode,
  input  logic                            restart_ext,
  input  logic                            reinitialize,
  input  logic [DIMENSION*IVAR_WIDTH-1:0] init_ivar,
  input  logic [DIMENSION*IVAR_WIDTH-1:0] ivar_next,
  input  logic [NUM_IC-1:0]               init_ic,
  input  logic [NUM_IC-1:0]               ic_in,
  input  logic [II_WIDTH-1:0]             iteration_interval,
  output logic                            conf_en,
  output logic [2:0]                      current_state,
  output logic [DIMENSION*IVAR_WIDTH-1:0] x_bus_reg,
  output logic [NUM_IC-1:0]               ic,
  output logic                            global_en,
  output logic                            tick,
  output logic [PASS_WIDTH-1:0]           pass_count,
  output logic                            done
);

  localparam int XW = DIMENSION*IVAR_WIDTH;
  localparam logic [NUM_IC-1:0] PE_KICK = NUM_IC'(pe_kick(NUM_IC));

  gc_state_e         state_q, state_d;
  logic [XW-1:0]     x_d;
  logic [NUM_IC-1:0] pipe_in;
  logic              done_d, pass_inc, en_d;
  logic              start_q, stop_q;
  logic [II_WIDTH-1:0] cnt, ii_eff;

  // ii = 0 behaves as 1 so the controller never stalls.
  assign ii_eff = (iteration_interval == '0) ? II_WIDTH'(1) : iteration_interval;
  assign tick   = config_done && (cnt == ii_eff - II_WIDTH'(1));

  // No guard against a shrinking ii: cnt above the new terminal value
  // simply runs up and wraps before the next tick.
  always_ff @(posedge gc_clk) begin
    if (reset || !config_done || tick) cnt <= '0;
    else                               cnt <= cnt + II_WIDTH'(1);
  end

  always_comb begin
    state_d  = state_q;
    x_d      = x_bus_reg;
    pipe_in  = '0;
    done_d   = 1'b0;
    pass_inc = 1'b0;
    case (state_q)
      ST_CONFIG: begin
        if (start_q && !stop_q && dcm_lock) begin
          state_d = ST_INIT;
          x_d     = init_ivar;
          pipe_in = init_ic;
        end else begin
          x_d = '0;
        end
      end
      ST_INIT: begin
        if (!stop_q) begin
          state_d = ST_RUN;
          x_d     = ivar_next;
          pipe_in = PE_KICK;
        end
      end
      ST_RUN: begin
        // stop outranks reinitialize; the last point is re-seen on resume
        if (stop_q) begin
          state_d = ST_PAUSE;
        end else if (reinitialize) begin
          done_d   = 1'b1;
          pass_inc = 1'b1;
          if (restart_mode || restart_ext) begin
            state_d = ST_INIT;
            x_d     = init_ivar;
            pipe_in = init_ic;
          end else begin
            state_d = ST_FINAL;
            x_d     = '0;
            pipe_in = ic_in;
          end
        end else begin
          x_d     = ivar_next;
          pipe_in = ic_in;
        end
      end
      ST_PAUSE: begin
        if (!stop_q) begin
          state_d = ST_RUN;
          x_d     = ivar_next;
          pipe_in = ic_in;
        end
      end
      ST_FINAL: begin
        if (restart_ext && !stop_q) begin
          state_d = ST_INIT;
          x_d     = init_ivar;
          pipe_in = init_ic;
        end else begin
          x_d = '0;
        end
      end
      default: begin
        state_d = ST_CONFIG;
        x_d     = '0;
      end
    endcase
    en_d = start_q && !stop_q && (state_q == ST_INIT || state_q == ST_RUN);
  end

  always_ff @(posedge gc_clk) begin
    if (reset) begin
      state_q    <= ST_CONFIG;
      x_bus_reg  <= '0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      global_en  <= 1'b0;
      done       <= 1'b0;
      pass_count <= '0;
    end else if (tick) begin
      state_q   <= state_d;
      x_bus_reg <= x_d;
      start_q   <= start;
      stop_q    <= stop;
      global_en <= en_d;
      done      <= done_d;
      if (pass_inc && pass_count != '1) pass_count <= pass_count + PASS_WIDTH'(1);
    end
  end

  gc_ic_delay #(
    .WIDTH (NUM_IC),
    .DEPTH (IC_DELAY)
  ) u_ic_delay (
    .clk      (gc_clk),
    .clear    (reset),
    .shift_en (tick),
    .din      (pipe_in),
    .dout     (ic)
  );

  assign current_state = state_q;
  assign conf_en       = (state_q == ST_CONFIG);

endmodule

// File: tb/tb_gc_sequencer.sv
module tb_gc_sequencer;
  import gc_pkg::*;

  localparam logic [47:0] INIT_V = 48'h0001_0002_0003;
  localparam logic [47:0] NEXT1  = 48'h0011_0012_0013;
  localparam logic [47:0] NEXT2  = 48'h0021_0022_0023;
  localparam logic [47:0] NEXT3  = 48'hFFFF_0031_8032;
  localparam logic [47:0] NEXT4  = 48'h0041_0042_0043;
  localparam logic [2:0]  IC_INIT = 3'b101;
  localparam logic [2:0]  IC_GEN  = 3'b010;

  logic        gc_clk = 1'b0;
  logic        reset, config_done, dcm_lock, start, stop;
  logic        restart_mode, restart_ext, reinitialize;
  logic [47:0] init_ivar, ivar_next;
  logic [2:0]  init_ic, ic_in;
  logic [15:0] iteration_interval;
  logic        conf_en, global_en, tick, done;
  logic [2:0]  current_state, ic;
  logic [47:0] x_bus_reg;
  logic [7:0]  pass_count;

  always #5 gc_clk = ~gc_clk;

  gc_sequencer #(
    .DIMENSION(3), .IVAR_WIDTH(16), .NUM_IC(3), .IC_DELAY(4),
    .II_WIDTH(16), .PASS_WIDTH(8)
  ) dut (
    .gc_clk(gc_clk), .reset(reset), .config_done(config_done),
    .dcm_lock(dcm_lock), .start(start), .stop(stop),
    .restart_mode(restart_mode), .restart_ext(restart_ext),
    .reinitialize(reinitialize), .init_ivar(init_ivar),
    .ivar_next(ivar_next), .init_ic(init_ic), .ic_in(ic_in),
    .iteration_interval(iteration_interval), .conf_en(conf_en),
    .current_state(current_state), .x_bus_reg(x_bus_reg), .ic(ic),
    .global_en(global_en), .tick(tick), .pass_count(pass_count),
    .done(done)
  );

  typedef struct {
    string       tag;
    logic [63:0] val;
  } sb_t;

  sb_t        sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  logic [2:0] p_hist [4];

  task automatic sb_push(input string tag, input logic [63:0] v);
    sb.push_back('{tag, v});
  endtask

  task automatic sb_check(input logic [63:0] obs);
    sb_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%0h expected=queued_entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic clear_hist();
    for (int i = 0; i < 4; i++) p_hist[i] = 3'b000;
  endtask

  // Wait for the next tick edge; returns cycles waited and whether x moved early.
  task automatic do_tick(output int nwait, output logic xmoved);
    logic [47:0] x0;
    x0     = x_bus_reg;
    nwait  = 0;
    xmoved = 1'b0;
    while (1) begin
      @(negedge gc_clk);
      nwait++;
      if (x_bus_reg !== x0) xmoved = 1'b1;
      if (tick === 1'b1) break;
      if (nwait >= 64) begin
        n_assert++;
        n_fail++;
        $error("FAIL tick_timeout observed=%0d expected=tick", nwait);
        return;
      end
    end
    @(posedge gc_clk);
    #1;
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [47:0] x,
                      input logic [2:0] pipe, input logic gen, input logic dn,
                      input logic [7:0] pc, input int exp_wait);
    int   nw;
    logic xm;
    p_hist[3] = p_hist[2];
    p_hist[2] = p_hist[1];
    p_hist[1] = p_hist[0];
    p_hist[0] = pipe;
    sb_push({tag, ".state"}, 64'(st));
    sb_push({tag, ".conf_en"}, 64'(st == 3'd0));
    sb_push({tag, ".x_bus"}, 64'(x));
    sb_push({tag, ".ic"}, 64'(p_hist[3]));
    sb_push({tag, ".global_en"}, 64'(gen));
    sb_push({tag, ".done"}, 64'(dn));
    sb_push({tag, ".pass_count"}, 64'(pc));
    sb_push({tag, ".wait"}, 64'(exp_wait));
    sb_push({tag, ".x_hold"}, 64'(0));
    do_tick(nw, xm);
    sb_check(64'(current_state));
    sb_check(64'(conf_en));
    sb_check(64'(x_bus_reg));
    sb_check(64'(ic));
    sb_check(64'(global_en));
    sb_check(64'(done));
    sb_check(64'(pass_count));
    sb_check(64'(nw));
    sb_check(64'(xm));
  endtask

  task automatic check_reset_values(input string tag);
    sb_push({tag, ".state"}, 64'(0));
    sb_push({tag, ".conf_en"}, 64'(1));
    sb_push({tag, ".x_bus"}, 64'(0));
    sb_push({tag, ".ic"}, 64'(0));
    sb_push({tag, ".global_en"}, 64'(0));
    sb_push({tag, ".done"}, 64'(0));
    sb_push({tag, ".pass_count"}, 64'(0));
    sb_push({tag, ".tick"}, 64'(0));
    sb_check(64'(current_state));
    sb_check(64'(conf_en));
    sb_check(64'(x_bus_reg));
    sb_check(64'(ic));
    sb_check(64'(global_en));
    sb_check(64'(done));
    sb_check(64'(pass_count));
    sb_check(64'(tick));
  endtask

  initial begin
    logic [7:0] pc;
    logic       frozen_bad;

    reset = 1'b1; config_done = 1'b0; dcm_lock = 1'b1;
    start = 1'b0; stop = 1'b0; restart_mode = 1'b0; restart_ext = 1'b0;
    reinitialize = 1'b0; init_ivar = INIT_V; ivar_next = NEXT1;
    init_ic = IC_INIT; ic_in = IC_GEN; iteration_interval = 16'd1;
    clear_hist();
    repeat (3) @(posedge gc_clk);
    #1;
    check_reset_values("por");

    // Startup with ii=1
    reset = 1'b0; config_done = 1'b1; start = 1'b1;
    step("t1_config", ST_CONFIG, 48'h0, 3'b000, 1'b0, 1'b0, 8'd0, 1);
    step("t2_init",   ST_INIT,   INIT_V, IC_INIT, 1'b0, 1'b0, 8'd0, 1);
    step("t3_run",    ST_RUN,    NEXT1, 3'b111, 1'b1, 1'b0, 8'd0, 1);
    step("t4_run",    ST_RUN,    NEXT1, IC_GEN, 1'b1, 1'b0, 8'd0, 1);
    step("t5_run",    ST_RUN,    NEXT1, IC_GEN, 1'b1, 1'b0, 8'd0, 1);
    step("t6_kick",   ST_RUN,    NEXT1, IC_GEN, 1'b1, 1'b0, 8'd0, 1);
    step("t7_run",    ST_RUN,    NEXT1, IC_GEN, 1'b1, 1'b0, 8'd0, 1);

    // Interval pacing: ii=5 then ii=0
    iteration_interval = 16'd5; ivar_next = NEXT2;
    step("ii5", ST_RUN, NEXT2, IC_GEN, 1'b1, 1'b0, 8'd0, 5);
    iteration_interval = 16'd0;
    step("ii0", ST_RUN, NEXT2, IC_GEN, 1'b1, 1'b0, 8'd0, 1);
    iteration_interval = 16'd1;

    // Stop / pause / resume
    ivar_next = NEXT3; stop = 1'b1;
    step("stop_a", ST_RUN,   NEXT3, IC_GEN, 1'b1, 1'b0, 8'd0, 1);
    ivar_next = NEXT4;
    step("stop_b", ST_PAUSE, NEXT3, 3'b000, 1'b0, 1'b0, 8'd0, 1);
    step("stop_c", ST_PAUSE, NEXT3, 3'b000, 1'b0, 1'b0, 8'd0, 1);
    step("stop_d", ST_PAUSE, NEXT3, 3'b000, 1'b0, 1'b0, 8'd0, 1);
    step("stop_e", ST_PAUSE, NEXT3, 3'b000, 1'b0, 1'b0, 8'd0, 1);
    stop = 1'b0;
    step("stop_f", ST_PAUSE, NEXT3, 3'b000, 1'b0, 1'b0, 8'd0, 1);
    step("resume", ST_RUN,   NEXT4, IC_GEN, 1'b0, 1'b0, 8'd0, 1);
    step("run_h",  ST_RUN,   NEXT4, IC_GEN, 1'b1, 1'b0, 8'd0, 1);

    // Last point without restart, then external restart
    reinitialize = 1'b1;
    step("fin_enter", ST_FINAL, 48'h0, IC_GEN, 1'b1, 1'b1, 8'd1, 1);
    reinitialize = 1'b0;
    step("fin_hold",  ST_FINAL, 48'h0, 3'b000, 1'b0, 1'b0, 8'd1, 1);
    restart_ext = 1'b1;
    step("fin_rst",   ST_INIT,  INIT_V, IC_INIT, 1'b0, 1'b0, 8'd1, 1);
    restart_ext = 1'b0;
    step("fin_run",   ST_RUN,   NEXT4, 3'b111, 1'b1, 1'b0, 8'd1, 1);

    // Auto-restart for 300 passes; pass_count saturates
    restart_mode = 1'b1; reinitialize = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      pc = (1 + k > 255) ? 8'd255 : 8'(1 + k);
      step("pass_init", ST_INIT, INIT_V, IC_INIT, 1'b1, 1'b1, pc, 1);
      step("pass_run",  ST_RUN,  NEXT4, 3'b111, 1'b1, 1'b0, pc, 1);
    end
    reinitialize = 1'b0; restart_mode = 1'b0;

    // Reset mid-RUN with ii=3
    iteration_interval = 16'd3;
    step("ii3_run", ST_RUN, NEXT4, IC_GEN, 1'b1, 1'b0, 8'd255, 3);
    @(posedge gc_clk);
    #1;
    reset = 1'b1;
    @(posedge gc_clk);
    #1;
    check_reset_values("mid_reset");
    clear_hist();

    // config_done low freezes the interval counter
    reset = 1'b0; config_done = 1'b0;
    frozen_bad = 1'b0;
    repeat (10) begin
      @(negedge gc_clk);
      if (tick !== 1'b0 || dut.cnt !== 16'd0 || current_state !== 3'd0) frozen_bad = 1'b1;
    end
    sb_push("cd_low.frozen", 64'(0));
    sb_check(64'(frozen_bad));
    @(posedge gc_clk);
    #1;
    config_done = 1'b1;
    step("cd_rise", ST_CONFIG, 48'h0, 3'b000, 1'b0, 1'b0, 8'd0, 3);
    step("cd_init", ST_INIT, INIT_V, IC_INIT, 1'b0, 1'b0, 8'd0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
